// File: rtl/c17_lane_pipe.sv
// Multi-lane c17 evaluator behind a two-stage valid/ready pipeline.
// Define C17_BIST_EN to add the LFSR/MISR self-test engine and its ports.
module c17_lane_pipe #(
   parameter int LANES    = 4,
   parameter int BIST_LEN = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*LANES-1:0] out_data
`ifdef C17_BIST_EN
   ,
   input  logic               bist_start,
   output logic               bist_busy,
   output logic               bist_done,
   output logic [15:0]        bist_sig
`endif
);

   if (LANES < 1 || LANES > 16 || BIST_LEN < 2 || BIST_LEN > 65535) begin : g_bad_param
      $error("c17_lane_pipe: LANES or BIST_LEN out of range");
   end

   logic               r_s1_valid;
   logic [LANES-1:0]   r_s1_w1;
   logic [LANES-1:0]   r_s1_w2;
   logic [LANES-1:0]   r_s1_w4;
   logic [LANES-1:0]   r_s1_w5;
   logic               r_s2_valid;
   logic [2*LANES-1:0] r_s2_data;

   logic               w_bist_act;
   logic               w_go;
   logic               w_s1_in_valid;
   logic [5*LANES-1:0] w_s1_in_data;
   logic               w_s2_load;
   logic               w_s1_load;
   logic [LANES-1:0]   w_n1;
   logic [LANES-1:0]   w_n2;
   logic [LANES-1:0]   w_n4;
   logic [LANES-1:0]   w_n5;
   logic [2*LANES-1:0] w_g;

   // A BIST run forces the consumer side ready so the pipe never stalls.
   assign w_s2_load = !r_s2_valid || out_ready || w_bist_act;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign in_ready  = w_s1_load && !w_bist_act && !w_go;
   assign out_valid = r_s2_valid && !w_bist_act;
   assign out_data  = r_s2_data;

   always_comb begin
      w_n1 = '0;
      w_n2 = '0;
      w_n4 = '0;
      w_n5 = '0;
      w_g  = '0;
      for (int k = 0; k < LANES; k++) begin
         w_n1[k]     = w_s1_in_data[5*k+4] & w_s1_in_data[5*k+1];
         w_n2[k]     = w_s1_in_data[5*k+4] & w_s1_in_data[5*k];
         w_n4[k]     = w_s1_in_data[5*k+3] & ~w_n1[k];
         w_n5[k]     = ~(w_s1_in_data[5*k+3] | w_s1_in_data[5*k+2]);
         w_g[2*k]    = r_s1_w2[k] | r_s1_w4[k];
         w_g[2*k+1]  = ~(r_s1_w5[k] | r_s1_w1[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_w1    <= '0;
         r_s1_w2    <= '0;
         r_s1_w4    <= '0;
         r_s1_w5    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= w_s1_in_valid;
            if (w_s1_in_valid) begin
               r_s1_w1 <= w_n1;
               r_s1_w2 <= w_n2;
               r_s1_w4 <= w_n4;
               r_s1_w5 <= w_n5;
            end
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2_data <= w_g;
         end
      end
   end

`ifdef C17_BIST_EN
   // state  | meaning
   // IDLE   | normal streaming; waits for bist_start with an empty pipe
   // RUN    | injects one LFSR pattern per cycle, BIST_LEN in total
   // DRAIN  | no injection; last beats flow through into the MISR
   // DONE   | signature final, bist_done raised; returns to IDLE
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} bist_state_t;

   localparam int          NCHUNK = (2*LANES + 15) / 16;
   localparam logic [15:0] LEN_M1 = 16'(BIST_LEN - 1);
   localparam logic [15:0] SEED   = 16'hACE1;

   bist_state_t         r_state;
   logic [15:0]         r_lfsr;
   logic [15:0]         r_misr;
   logic [15:0]         r_cnt;
   logic                r_busy;
   logic                r_done;
   logic [5*LANES-1:0]  w_pat;
   logic [16*NCHUNK-1:0] w_ext;
   logic [15:0]         w_fold;
   logic [15:0]         w_lfsr_nxt;
   logic [15:0]         w_misr_nxt;

   assign w_bist_act    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_go          = (r_state == ST_IDLE) && bist_start && !r_s1_valid && !r_s2_valid;
   assign w_s1_in_valid = (r_state == ST_RUN) || (in_valid && in_ready);
   assign w_s1_in_data  = (r_state == ST_RUN) ? w_pat : in_data;

   always_comb begin
      w_pat = '0;
      for (int k = 0; k < LANES; k++)
         for (int i = 0; i < 5; i++)
            w_pat[5*k+i] = r_lfsr[(5*k+i) % 16];
      w_ext = '0;
      w_ext[2*LANES-1:0] = r_s2_data;
      w_fold = '0;
      for (int c = 0; c < NCHUNK; c++)
         w_fold = w_fold ^ w_ext[16*c +: 16];
   end

   assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_misr_nxt = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]} ^ w_fold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_lfsr  <= SEED;
         r_misr  <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_state <= ST_RUN;
                  r_lfsr  <= SEED;
                  r_misr  <= '0;
                  r_cnt   <= LEN_M1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               r_lfsr <= w_lfsr_nxt;
               if (r_s2_valid) r_misr <= w_misr_nxt;
               if (r_cnt == 16'd0) r_state <= ST_DRAIN;
               else                r_cnt   <= r_cnt - 16'd1;
            end
            ST_DRAIN: begin
               if (r_s2_valid) r_misr <= w_misr_nxt;
               // Stage 2 empties on this edge once stage 1 has nothing left.
               if (!r_s1_valid) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bist_busy = r_busy;
   assign bist_done = r_done;
   assign bist_sig  = r_misr;
`else
   assign w_bist_act    = 1'b0;
   assign w_go          = 1'b0;
   assign w_s1_in_valid = in_valid && in_ready;
   assign w_s1_in_data  = in_data;
`endif

endmodule

// File: tb/tb_c17_lane_pipe.sv
// Randomised bench for c17_lane_pipe (LANES=4) against a transaction-level model.
// BIST checks are compiled in when C17_BIST_EN is defined.
module tb_c17_lane_pipe;
   localparam int LANES = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [5*LANES-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [2*LANES-1:0] out_data;
`ifdef C17_BIST_EN
   logic               bist_start;
   logic               bist_busy;
   logic               bist_done;
   logic [15:0]        bist_sig;
`endif

   c17_lane_pipe #(.LANES(LANES), .BIST_LEN(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef C17_BIST_EN
      ,
      .bist_start(bist_start),
      .bist_busy (bist_busy),
      .bist_done (bist_done),
      .bist_sig  (bist_sig)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*LANES-1:0] d;
      int                 c;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_err    = 0;
   int    cyc      = 0;
   int    n_out    = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [2*LANES-1:0] c17_ref(input logic [5*LANES-1:0] d);
      logic [2*LANES-1:0] r;
      logic g1, g2, g3, g4, g5, w1, w2, w4, w5;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         {g5, g4, g3, g2, g1} = d[5*k +: 5];
         w1 = g5 & g2;
         w2 = g5 & g1;
         w4 = g4 & ~w1;
         w5 = ~(g4 | g3);
         r[2*k]   = w2 | w4;
         r[2*k+1] = ~(w5 | w1);
      end
      return r;
   endfunction

   // One clock cycle: drive, check handshake against the occupancy model, score transfers.
   task automatic drive(input logic v, input logic [5*LANES-1:0] d, input logic r, output logic acc);
      beat_t b;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      check_val("in_ready", in_ready, (q.size() < 2) || r);
      check_val("out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].c + 2));
      if (out_valid && out_ready) begin
         if (q.size() == 0) check_val("spurious_out", out_valid, 1'b0);
         else begin
            check_val("out_data", out_data, q[0].d);
            void'(q.pop_front());
            n_out++;
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         b.d = c17_ref(d);
         b.c = cyc;
         q.push_back(b);
      end
      cyc++;
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 6 && q.size() > 0; i++) drive(1'b0, '0, 1'b1, acc);
      check_val("drained", q.size(), 0);
   endtask

`ifdef C17_BIST_EN
   function automatic logic [15:0] bist_ref(input int len);
      logic [15:0]        lfsr, misr, dw;
      logic [5*LANES-1:0] pat;
      logic [2*LANES-1:0] o;
      lfsr = 16'hACE1;
      misr = 16'h0000;
      for (int n = 0; n < len; n++) begin
         for (int b = 0; b < 5*LANES; b++) pat[b] = lfsr[b % 16];
         o  = c17_ref(pat);
         dw = '0;
         for (int b = 0; b < 2*LANES; b++) dw[b % 16] = dw[b % 16] ^ o[b];
         misr = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ dw;
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      return misr;
   endfunction

   task automatic bist_run(output logic [15:0] sig);
      int busy_cnt;
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = 20'(($urandom));
      out_ready  = 1'b0;
      bist_start = 1'b1;
      @(negedge clk);
      bist_start = 1'b0;
      #1;
      busy_cnt = 0;
      while (bist_busy && busy_cnt < 1000) begin
         busy_cnt++;
         if (busy_cnt == 10) begin
            check_val("bist_in_ready", in_ready, 1'b0);
            check_val("bist_out_valid", out_valid, 1'b0);
         end
         @(negedge clk);
         in_data = 20'(($urandom));
         #1;
      end
      in_valid = 1'b0;
      check_val("bist_busy_cycles", busy_cnt, 258);
      check_val("bist_done", bist_done, 1'b1);
      check_val("bist_sig", bist_sig, bist_ref(256));
      check_val("bist_pipe_empty", out_valid, 1'b0);
      sig = bist_sig;
   endtask
`endif

   initial begin
      logic                acc;
      logic [5*LANES-1:0]  pend_d;
      logic                pend_v;
      logic [2*LANES-1:0]  held;
      int                  n_acc;
      int                  sent;
`ifdef C17_BIST_EN
      logic [15:0]         sig1, sig2;
      bist_start = 1'b0;
`endif
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_out_data", out_data, 8'h00);
`ifdef C17_BIST_EN
      check_val("rst_bist_busy", bist_busy, 1'b0);
      check_val("rst_bist_done", bist_done, 1'b0);
      check_val("rst_bist_sig", bist_sig, 16'h0000);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Directed corner values with latency visible through the out_valid model.
      drive(1'b1, 20'h00000, 1'b1, acc);
      drive(1'b1, 20'hFFFFF, 1'b1, acc);
      drive(1'b0, '0, 1'b1, acc);
      drain();

      // All 32 values on lane 0, back-to-back.
      n_out = 0;
      for (int v = 0; v < 32; v++) drive(1'b1, 20'(v), 1'b1, acc);
      drain();
      check_val("exhaustive_count", n_out, 32);

      // Stall: five attempts with the consumer blocked; only two fit.
      n_acc  = 0;
      sent   = 0;
      pend_d = 20'(($urandom));
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, pend_d, 1'b0, acc);
         if (acc) begin n_acc++; sent++; pend_d = 20'(($urandom)); end
         if (i == 2) held = out_data;
         if (i > 2) check_val("stall_hold", out_data, held);
      end
      check_val("stall_accepted", n_acc, 2);
      n_out = 0;
      for (int i = 0; i < 20 && sent < 5; i++) begin
         drive(1'b1, pend_d, 1'b1, acc);
         if (acc) begin sent++; pend_d = 20'(($urandom)); end
      end
      drain();
      check_val("stall_delivered", n_out, 5);

      // Bubbles: alternating valid, consumer always ready.
      for (int i = 0; i < 16; i++) begin
         drive(1'(i % 2 == 0), 20'(($urandom)), 1'b1, acc);
         check_val("bubble_ready", in_ready, 1'b1);
      end
      drain();

      // Random traffic; producer holds a beat until it is taken.
      pend_v = 1'b0;
      pend_d = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend_v) begin
            pend_v = 1'(($urandom_range(0, 3) != 0));
            pend_d = 20'(($urandom));
         end
         drive(pend_v, pend_d, 1'(($urandom_range(0, 2) != 0)), acc);
         if (acc) pend_v = 1'b0;
      end
      drain();

      // Reset with two beats in flight.
      drive(1'b1, 20'(($urandom)), 1'b0, acc);
      drive(1'b1, 20'(($urandom)), 1'b0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_val("midrst_out_valid", out_valid, 1'b0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, acc);
      drive(1'b1, 20'hFFFFF, 1'b1, acc);
      drain();

`ifdef C17_BIST_EN
      bist_run(sig1);
      @(negedge clk);
      #1;
      check_val("bist_done_sticky", bist_done, 1'b1);
      bist_run(sig2);
      check_val("bist_repeat", sig2, sig1);
      drive(1'b1, 20'(($urandom)), 1'b1, acc);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
